// File: rtl/ins_cache_dm.sv
// Direct-mapped, read-only instruction cache: single-cycle hits, whole-line in-order refill over a
// req/ack memory port, full flush, and wrapping hit/miss event counters.
module ins_cache_dm #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned INDEX_BITS  = 8,
  parameter int unsigned OFFSET_BITS = 2
) (
  input  logic              ins_cache_dm_clock_in,
  input  logic              ins_cache_dm_reset_in,
  input  logic              ins_cache_dm_req_valid_in,
  input  logic [ADDR_W-1:0] ins_cache_dm_addr_in,
  output logic              ins_cache_dm_ready_out,
  output logic              ins_cache_dm_resp_valid_out,
  output logic              ins_cache_dm_hit_out,
  output logic [DATA_W-1:0] ins_cache_dm_data_out,
  input  logic              ins_cache_dm_flush_in,
  output logic              ins_cache_dm_mem_req_out,
  output logic [ADDR_W-1:0] ins_cache_dm_mem_addr_out,
  input  logic              ins_cache_dm_mem_ack_in,
  input  logic [DATA_W-1:0] ins_cache_dm_mem_data_in,
  output logic [31:0]       ins_cache_dm_hit_cnt_out,
  output logic [31:0]       ins_cache_dm_miss_cnt_out
);

  localparam int unsigned TAG_BITS   = ADDR_W - INDEX_BITS - OFFSET_BITS - 2;
  localparam int unsigned LINES      = 1 << INDEX_BITS;
  localparam int unsigned LINE_WORDS = 1 << OFFSET_BITS;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StRefill = 2'd1;
  localparam logic [1:0] StResp   = 2'd2;

  logic                   clk;
  logic                   rst;
  assign clk = ins_cache_dm_clock_in;
  assign rst = ins_cache_dm_reset_in;

  // Storage
  logic [DATA_W-1:0]      data_mem [LINES*LINE_WORDS];
  logic [TAG_BITS-1:0]    tag_mem  [LINES];
  logic [LINES-1:0]       valid_q, valid_d;

  // Control state
  logic [1:0]             state_q, state_d;
  logic [OFFSET_BITS-1:0] k_q, k_d;
  logic [TAG_BITS-1:0]    tag_q, tag_d;
  logic [INDEX_BITS-1:0]  index_q, index_d;
  logic [OFFSET_BITS-1:0] offset_q, offset_d;
  logic                   flush_pend_q, flush_pend_d;
  logic                   resp_valid_q, resp_valid_d;
  logic                   hit_q, hit_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic [31:0]            hit_cnt_q, miss_cnt_q;

  logic                   hit_inc, miss_inc;
  logic                   data_we, tag_we;

  // Request address split; byte-lane bits are not used by a word-granular fetch
  logic [TAG_BITS-1:0]    req_tag;
  logic [INDEX_BITS-1:0]  req_index;
  logic [OFFSET_BITS-1:0] req_offset;
  logic [1:0]             unused_byte_bits;

  assign req_offset       = ins_cache_dm_addr_in[OFFSET_BITS+1:2];
  assign req_index        = ins_cache_dm_addr_in[INDEX_BITS+OFFSET_BITS+1:OFFSET_BITS+2];
  assign req_tag          = ins_cache_dm_addr_in[ADDR_W-1:INDEX_BITS+OFFSET_BITS+2];
  assign unused_byte_bits = ins_cache_dm_addr_in[1:0];

  logic                   lookup_hit;
  logic [DATA_W-1:0]      lookup_word;
  logic                   accept;
  logic                   mem_ack;
  logic                   last_word;
  logic                   flush_now;

  assign lookup_hit  = valid_q[req_index] && (tag_mem[req_index] == req_tag);
  assign lookup_word = data_mem[{req_index, req_offset}];
  assign accept      = ins_cache_dm_req_valid_in && (state_q == StIdle);
  assign mem_ack     = ins_cache_dm_mem_ack_in && (state_q == StRefill);
  assign last_word   = &k_q;
  assign flush_now   = flush_pend_q || ins_cache_dm_flush_in;

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    tag_d        = tag_q;
    index_d      = index_q;
    offset_d     = offset_q;
    flush_pend_d = flush_pend_q;
    valid_d      = valid_q;
    resp_valid_d = 1'b0;
    hit_d        = 1'b0;
    rdata_d      = rdata_q;
    hit_inc      = 1'b0;
    miss_inc     = 1'b0;
    data_we      = 1'b0;
    tag_we       = 1'b0;

    case (state_q)
      StIdle: begin
        // The lookup above sees pre-flush valid bits, so a same-cycle request still hits
        if (ins_cache_dm_flush_in) valid_d = '0;
        if (accept) begin
          if (lookup_hit) begin
            resp_valid_d = 1'b1;
            hit_d        = 1'b1;
            rdata_d      = lookup_word;
            hit_inc      = 1'b1;
          end else begin
            tag_d    = req_tag;
            index_d  = req_index;
            offset_d = req_offset;
            k_d      = '0;
            miss_inc = 1'b1;
            state_d  = StRefill;
          end
        end
      end

      StRefill: begin
        if (ins_cache_dm_flush_in) flush_pend_d = 1'b1;
        if (mem_ack) begin
          data_we = 1'b1;
          k_d     = k_q + 1'b1;
          if (last_word) begin
            tag_we = 1'b1;
            if (!flush_now) valid_d[index_q] = 1'b1;
            resp_valid_d = 1'b1;
            // The requested word may be the one arriving on this very ack
            rdata_d = (k_q == offset_q) ? ins_cache_dm_mem_data_in
                                        : data_mem[{index_q, offset_q}];
            state_d = StResp;
          end
        end
      end

      StResp: begin
        if (flush_now) valid_d = '0;
        flush_pend_d = 1'b0;
        state_d      = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      k_q          <= '0;
      tag_q        <= '0;
      index_q      <= '0;
      offset_q     <= '0;
      flush_pend_q <= 1'b0;
      valid_q      <= '0;
      resp_valid_q <= 1'b0;
      hit_q        <= 1'b0;
      rdata_q      <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      tag_q        <= tag_d;
      index_q      <= index_d;
      offset_q     <= offset_d;
      flush_pend_q <= flush_pend_d;
      valid_q      <= valid_d;
      resp_valid_q <= resp_valid_d;
      hit_q        <= hit_d;
      rdata_q      <= rdata_d;
      if (hit_inc)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_inc) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  // Arrays carry no reset; the valid bits alone decide whether their contents are used
  always_ff @(posedge clk) begin
    if (!rst && data_we) data_mem[{index_q, k_q}] <= ins_cache_dm_mem_data_in;
    if (!rst && tag_we)  tag_mem[index_q]         <= tag_q;
  end

  assign ins_cache_dm_ready_out      = (state_q == StIdle);
  assign ins_cache_dm_resp_valid_out = resp_valid_q;
  assign ins_cache_dm_hit_out        = hit_q;
  assign ins_cache_dm_data_out       = rdata_q;
  assign ins_cache_dm_mem_req_out    = (state_q == StRefill);
  assign ins_cache_dm_mem_addr_out   = (state_q == StRefill) ? {tag_q, index_q, k_q, 2'b00}
                                                             : '0;
  assign ins_cache_dm_hit_cnt_out    = hit_cnt_q;
  assign ins_cache_dm_miss_cnt_out   = miss_cnt_q;

endmodule

// File: tb/tb_ins_cache_dm.sv
// Directed bench for ins_cache_dm: vector table of fetches plus hand sequences for flush, memory
// stalls, reset mid-refill, counter wrap, and an 8-word-line configuration.
module tb_ins_cache_dm;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] addr = '0;
  logic        flush = 1'b0;
  logic        ready, resp_valid, hit;
  logic [31:0] rdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_data = '0;
  logic [31:0] hit_cnt, miss_cnt;

  // Second instance: 16 lines of 8 words
  logic        req2 = 1'b0;
  logic [31:0] addr2 = '0;
  logic        ready2, resp2, hit2;
  logic [31:0] data2;
  logic        mreq2;
  logic [31:0] maddr2;
  logic        mack2 = 1'b0;
  logic [31:0] mdata2 = '0;
  logic [31:0] hc2, mc2;

  int checks = 0;
  int failures = 0;

  ins_cache_dm dut (
    .ins_cache_dm_clock_in      (clk),
    .ins_cache_dm_reset_in      (rst),
    .ins_cache_dm_req_valid_in  (req_valid),
    .ins_cache_dm_addr_in       (addr),
    .ins_cache_dm_ready_out     (ready),
    .ins_cache_dm_resp_valid_out(resp_valid),
    .ins_cache_dm_hit_out       (hit),
    .ins_cache_dm_data_out      (rdata),
    .ins_cache_dm_flush_in      (flush),
    .ins_cache_dm_mem_req_out   (mem_req),
    .ins_cache_dm_mem_addr_out  (mem_addr),
    .ins_cache_dm_mem_ack_in    (mem_ack),
    .ins_cache_dm_mem_data_in   (mem_data),
    .ins_cache_dm_hit_cnt_out   (hit_cnt),
    .ins_cache_dm_miss_cnt_out  (miss_cnt)
  );

  ins_cache_dm #(.INDEX_BITS(4), .OFFSET_BITS(3)) dut8 (
    .ins_cache_dm_clock_in      (clk),
    .ins_cache_dm_reset_in      (rst),
    .ins_cache_dm_req_valid_in  (req2),
    .ins_cache_dm_addr_in       (addr2),
    .ins_cache_dm_ready_out     (ready2),
    .ins_cache_dm_resp_valid_out(resp2),
    .ins_cache_dm_hit_out       (hit2),
    .ins_cache_dm_data_out      (data2),
    .ins_cache_dm_flush_in      (1'b0),
    .ins_cache_dm_mem_req_out   (mreq2),
    .ins_cache_dm_mem_addr_out  (maddr2),
    .ins_cache_dm_mem_ack_in    (mack2),
    .ins_cache_dm_mem_data_in   (mdata2),
    .ins_cache_dm_hit_cnt_out   (hc2),
    .ins_cache_dm_miss_cnt_out  (mc2)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:4] == 28'h0000010) return 32'hA0 + 32'(a[3:2]);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory model: acks any request on the following edge unless a stall is armed for a word
  int          stall_word = -1;
  int          stall_left = 0;
  logic [31:0] ack_log[$];
  logic [31:0] log2[$];

  always @(negedge clk) begin
    if (mem_req && int'(mem_addr[3:2]) == stall_word && stall_left > 0) begin
      mem_ack = 1'b0;
      stall_left--;
    end else if (mem_req) begin
      mem_ack  = 1'b1;
      mem_data = mem_word(mem_addr);
      ack_log.push_back(mem_addr);
    end else begin
      mem_ack = 1'b0;
    end
  end

  always @(negedge clk) begin
    mack2  = mreq2;
    mdata2 = 32'hB0 + 32'(maddr2[4:2]);
    if (mreq2) log2.push_back(maddr2);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic with_flush);
    @(negedge clk);
    check("ready_before_req", 32'(ready), 32'd1);
    req_valid = 1'b1;
    addr      = a;
    flush     = with_flush;
    @(negedge clk);
    req_valid = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic wait_resp(input string name, input logic exp_hit, input logic [31:0] exp_data,
                           output int lat);
    lat = 0;
    while (!resp_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    if (!resp_valid) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: no response within %0d cycles, required one", name, lat);
    end else begin
      check({name, "_hit"}, 32'(hit), 32'(exp_hit));
      check({name, "_data"}, rdata, exp_data);
    end
  endtask

  task automatic fetch(input string name, input logic [31:0] a, input logic exp_hit,
                       input logic [31:0] exp_data);
    int lat;
    issue(a, 1'b0);
    wait_resp(name, exp_hit, exp_data, lat);
    check({name, "_lat"}, 32'(lat), exp_hit ? 32'd0 : 32'd4);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        exp_hit;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat;
    int n;

    vecs[0] = '{32'h0000_0100, 1'b1, 32'h0000_00A0};
    vecs[1] = '{32'h0000_0107, 1'b1, 32'h0000_00A1};
    vecs[2] = '{32'h0000_1100, 1'b0, 32'h5A5A_1100};
    vecs[3] = '{32'h0000_110C, 1'b1, 32'h5A5A_110C};
    vecs[4] = '{32'h0000_0100, 1'b0, 32'h0000_00A0};
    vecs[5] = '{32'h0000_1104, 1'b0, 32'h5A5A_1104};
    vecs[6] = '{32'h0000_020C, 1'b0, 32'h5A5A_020C};
    vecs[7] = '{32'h0000_0200, 1'b1, 32'h5A5A_0200};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_hit", 32'(hit), 32'd0);
    check("rst_data", rdata, 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_hit_cnt", hit_cnt, 32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);
    rst = 1'b0;

    // First miss refills words in order
    ack_log.delete();
    fetch("t1", 32'h0000_0100, 1'b0, 32'h0000_00A0);
    check("t1_nacks", 32'(ack_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < ack_log.size(); i++)
      check("t1_ack_addr", ack_log[i], 32'h100 + 32'(i * 4));
    check("t1_miss_cnt", miss_cnt, 32'd1);
    check("t1_hit_cnt", hit_cnt, 32'd0);

    // Back-to-back hits
    @(negedge clk);
    req_valid = 1'b1;
    addr      = 32'h108;
    @(negedge clk);
    check("t2_resp0_valid", 32'(resp_valid), 32'd1);
    check("t2_resp0_hit", 32'(hit), 32'd1);
    check("t2_resp0_data", rdata, 32'hA2);
    check("t2_ready0", 32'(ready), 32'd1);
    addr = 32'h10C;
    @(negedge clk);
    req_valid = 1'b0;
    check("t2_resp1_valid", 32'(resp_valid), 32'd1);
    check("t2_resp1_hit", 32'(hit), 32'd1);
    check("t2_resp1_data", rdata, 32'hA3);
    check("t2_ready1", 32'(ready), 32'd1);
    @(negedge clk);
    check("t2_resp_idle", 32'(resp_valid), 32'd0);
    check("t2_data_hold", rdata, 32'hA3);
    check("t2_hit_cnt", hit_cnt, 32'd2);

    // Vector table: conflicts, ignored byte bits, fill order for a non-zero offset
    for (int v = 0; v < 8; v++) begin
      ack_log.delete();
      fetch($sformatf("vec%0d", v), vecs[v].addr, vecs[v].exp_hit, vecs[v].exp_data);
      if (vecs[v].exp_hit) begin
        check($sformatf("vec%0d_nacks", v), 32'(ack_log.size()), 32'd0);
      end else begin
        check($sformatf("vec%0d_nacks", v), 32'(ack_log.size()), 32'd4);
        if (ack_log.size() == 4) begin
          check($sformatf("vec%0d_first", v), ack_log[0], {vecs[v].addr[31:4], 4'h0});
          check($sformatf("vec%0d_last", v), ack_log[3], {vecs[v].addr[31:4], 4'hC});
        end
      end
    end
    check("vec_hit_cnt", hit_cnt, 32'd6);
    check("vec_miss_cnt", miss_cnt, 32'd5);

    // Flush in IDLE with a same-cycle request: answered from pre-flush state
    issue(32'h200, 1'b1);
    wait_resp("t4_flush_req", 1'b1, 32'h5A5A_0200, lat);
    check("t4_flush_req_lat", 32'(lat), 32'd0);
    check("t4_hit_cnt", hit_cnt, 32'd7);
    fetch("t4_after_flush", 32'h204, 1'b0, 32'h5A5A_0204);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    fetch("t4_idle_flush", 32'h208, 1'b0, 32'h5A5A_0208);

    // Flush during refill: data returned, but nothing stays valid
    issue(32'h300, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_resp("t4_mid_flush", 1'b0, 32'h5A5A_0300, lat);
    fetch("t4_refetch", 32'h300, 1'b0, 32'h5A5A_0300);
    fetch("t4_other_line", 32'h208, 1'b0, 32'h5A5A_0208);
    check("t4_miss_cnt", miss_cnt, 32'd10);

    // Memory stall on word 2: request and address held, cache not ready
    stall_word = 2;
    stall_left = 5;
    issue(32'h100, 1'b0);
    n = 0;
    while (mem_addr !== 32'h108 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t5_reached_word2", mem_addr, 32'h108);
    for (int j = 0; j < 5; j++) begin
      check("t5_stall_req", 32'(mem_req), 32'd1);
      check("t5_stall_addr", mem_addr, 32'h108);
      check("t5_stall_ready", 32'(ready), 32'd0);
      @(negedge clk);
    end
    stall_word = -1;
    wait_resp("t5_stall", 1'b0, 32'hA0, lat);
    check("t5_miss_cnt", miss_cnt, 32'd11);

    // Reset during refill aborts it
    issue(32'h400, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_mem_req", 32'(mem_req), 32'd0);
    check("t5_rst_ready", 32'(ready), 32'd1);
    check("t5_rst_miss_cnt", miss_cnt, 32'd0);
    rst = 1'b0;
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) n++;
    end
    check("t5_no_stray_resp", 32'(n), 32'd0);
    fetch("t5_line_invalid", 32'h100, 1'b0, 32'hA0);
    fetch("t5_aborted_line", 32'h400, 1'b0, 32'h5A5A_0400);

    // Hit counter wrap
    @(negedge clk);
    force dut.hit_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.hit_cnt_q;
    check("t6_preload", hit_cnt, 32'hFFFF_FFFF);
    fetch("t6_hit", 32'h404, 1'b1, 32'h5A5A_0404);
    check("t6_wrap", hit_cnt, 32'd0);

    // 8-word lines
    log2.delete();
    @(negedge clk);
    req2  = 1'b1;
    addr2 = 32'h100;
    @(negedge clk);
    req2 = 1'b0;
    n = 0;
    while (!resp2 && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("t6b_lat", 32'(n), 32'd8);
    check("t6b_hit", 32'(hit2), 32'd0);
    check("t6b_data", data2, 32'hB0);
    check("t6b_nacks", 32'(log2.size()), 32'd8);
    for (int i = 0; i < 8 && i < log2.size(); i++)
      check("t6b_ack_addr", log2[i], 32'h100 + 32'(i * 4));
    @(negedge clk);
    req2  = 1'b1;
    addr2 = 32'h11C;
    @(negedge clk);
    req2 = 1'b0;
    check("t6b_hit_valid", 32'(resp2), 32'd1);
    check("t6b_hit_flag", 32'(hit2), 32'd1);
    check("t6b_hit_data", data2, 32'hB7);
    check("t6b_hit_cnt", hc2, 32'd1);
    check("t6b_miss_cnt", mc2, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time, checks=%0d failures=%0d",
             checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
